// File: rtl/board_arb_pkg.sv
// Shared types and defaults for the tetris board RAM arbiter.
package board_arb_pkg;

  localparam int DEF_ADDR_W     = 9;
  localparam int DEF_DEPTH      = 512;
  localparam int DEF_STARVE_MAX = 15;

  typedef enum logic {ST_IDLE, ST_CLEAR} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_GL, OWN_CLR} owner_t;

  // Read-return tag carried alongside the RAM's one-cycle read latency.
  typedef struct packed {
    owner_t owner;
    logic   gl_rd;
    logic   oor;
    logic   vga_miss;
  } rd_tag_t;

endpackage

// File: rtl/board_clear_seq.sv
// Board-clear sequencer: walks clr_ptr over every cell, stepping only when granted.
module board_clear_seq
  import board_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  output logic              busy,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] ptr_nxt;

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (advance) begin
          if (ptr == LAST) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CLEAR);

endmodule

// File: rtl/board_mem_arbiter.sv
// Arbitrates the single-port 1-bit board RAM between VGA fetch, game logic and board clear.
module board_mem_arbiter
  import board_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_bit,
  output logic              vga_miss,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic              gl_wdata,
  output logic              gl_gnt,
  output logic              gl_rvalid,
  output logic              gl_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_wdata,
  input  logic              mem_rdata
);

  localparam int                SW         = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [ADDR_W:0]   DEPTH_LIM  = (ADDR_W + 1)'(DEPTH);

  owner_t            owner;
  logic [SW-1:0]     starve_cnt;
  logic [ADDR_W-1:0] clr_ptr;
  logic              gl_in_range;
  logic              mem_we_raw;
  rd_tag_t           tag_d, tag_q;

  board_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .start     (clr_start),
    .advance   (owner == OWN_CLR),
    .busy      (clr_busy),
    .ptr       (clr_ptr)
  );

  assign gl_in_range = ({1'b0, gl_addr} < DEPTH_LIM);

  always_comb begin
    owner = OWN_NONE;
    if (clr_busy)
      owner = vga_req ? OWN_VGA : OWN_CLR;
    else if (gl_req && (starve_cnt == STARVE_LIM))
      owner = OWN_GL;
    else if (vga_req)
      owner = OWN_VGA;
    else if (gl_req)
      owner = OWN_GL;
  end

  assign gl_gnt = (owner == OWN_GL);

  always_comb begin
    mem_addr   = vga_addr;
    mem_we_raw = 1'b0;
    mem_wdata  = 1'b0;
    case (owner)
      OWN_GL: begin
        mem_addr   = gl_addr;
        mem_we_raw = gl_we && gl_in_range;
        mem_wdata  = gl_wdata;
      end
      OWN_CLR: begin
        mem_addr   = clr_ptr;
        mem_we_raw = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_we = mem_we_raw && reset;

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (clr_busy || !gl_req || gl_gnt)
      starve_cnt <= '0;
    else if (starve_cnt != STARVE_LIM)
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb begin
    tag_d.owner    = owner;
    tag_d.gl_rd    = (owner == OWN_GL) && !gl_we;
    tag_d.oor      = !gl_in_range;
    tag_d.vga_miss = vga_req && (owner != OWN_VGA);
  end

  // Stage 1 tags the owner while the RAM reads; stage 2 captures mem_rdata into the outputs.
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      tag_q     <= '{owner: OWN_NONE, gl_rd: 1'b0, oor: 1'b0, vga_miss: 1'b0};
      vga_bit   <= 1'b0;
      vga_miss  <= 1'b0;
      gl_rvalid <= 1'b0;
      gl_rdata  <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      vga_miss  <= tag_q.vga_miss;
      gl_rvalid <= tag_q.gl_rd;
      if (tag_q.owner == OWN_VGA)
        vga_bit <= mem_rdata;
      if (tag_q.gl_rd)
        gl_rdata <= tag_q.oor ? 1'b0 : mem_rdata;
    end
  end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Shares the single-port, 1-bit-wide tetris board RAM (512 cells) between three clients:
  - the VGA pixel fetch path (vga_controller Bit_addr/bitin),
  - the game-logic read/write port,
  - a built-in board-clear sequencer.
- Sits between vga_controller, game logic and the board RAM in the 25 MHz clock domain.
- VGA has priority. Starvation protection guarantees game-logic progress.

Parameters:
- ADDR_W, 9, board address width.
- DEPTH, 512, number of board cells; must be <= 2**ADDR_W.
- STARVE_MAX, 15, consecutive denied game-logic cycles before it overrides VGA.

Ports:
- clk_25mhz  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- vga_req  in  1  VGA read request this cycle.
- vga_addr  in  ADDR_W  VGA read address.
- vga_bit  out  1  registered VGA pixel bit.
- vga_miss  out  1  registered pulse: a VGA request was not served.
- gl_req  in  1  game-logic request; held until gl_gnt.
- gl_we  in  1  1 = write, 0 = read.
- gl_addr  in  ADDR_W  game-logic address.
- gl_wdata  in  1  game-logic write data.
- gl_gnt  out  1  combinational grant; request accepted this cycle.
- gl_rvalid  out  1  registered read-return strobe.
- gl_rdata  out  1  registered read data.
- clr_start  in  1  start clearing the whole board to 0.
- clr_busy  out  1  registered; clear in progress.
- mem_addr  out  ADDR_W  RAM address (combinational).
- mem_we  out  1  RAM write enable (combinational).
- mem_wdata  out  1  RAM write data (combinational).
- mem_rdata  in  1  RAM read data, one cycle after address (synchronous RAM).

Behaviour:
- Reset (reset=0, asynchronous):
  - vga_bit, vga_miss, gl_rvalid, gl_rdata, clr_busy all 0.
  - State IDLE; starve_cnt=0; clr_ptr=0.
  - mem_we forced 0 while reset is low.
  - Reset during a clear aborts it; the board is left partially cleared.
- States: IDLE and CLEAR. clr_busy = (state==CLEAR).
- Arbitration in IDLE, decided combinationally from cycle-N inputs:
  1. gl_req && starve_cnt==STARVE_MAX -> game.
  2. else vga_req -> VGA.
  3. else gl_req -> game.
  4. else no owner: mem_addr=vga_addr, mem_we=0.
- Arbitration in CLEAR:
  - vga_req -> VGA; else -> clear write (mem_addr=clr_ptr, mem_we=1, mem_wdata=0).
  - Game is never granted in CLEAR; gl_gnt=0 and starve_cnt held at 0.
- gl_gnt=1 in cycle N only when game owns the RAM.
  - Game write: mem_we=1, mem_wdata=gl_wdata.
  - Game read: mem_we=0.
  - An address >= DEPTH is still granted; the write is suppressed and a read returns 0.
- Read latency: a read owned in cycle N puts data on mem_rdata in N+1, registered at the end of N+1.
  - VGA: vga_bit updates in cycle N+2.
  - Game read: gl_rvalid=1 for exactly one cycle (N+2), with gl_rdata valid that cycle.
  - Game write: gl_rvalid is never asserted.
- vga_miss:
  - 1 in cycle N+2 iff vga_req=1 in N and VGA was not the owner.
  - On a miss, vga_bit holds its previous value (stale pixel, no glitch).
- starve_cnt (IDLE only):
  - Increments, saturating at STARVE_MAX, when gl_req && !gl_gnt.
  - Clears to 0 when gl_gnt or !gl_req.
  - So under continuous vga_req a game request is granted on its (STARVE_MAX+1)-th cycle.
- Clear sequence:
  - clr_start in IDLE -> CLEAR next cycle with clr_ptr=0.
  - In cycle N of clr_start, a game request is still arbitrated normally.
  - clr_ptr increments only on cycles where the clear writes.
  - The cycle that writes DEPTH-1 transitions to IDLE; clr_busy falls the next cycle.
  - clr_start during CLEAR is ignored; there is no restart.
  - With vga_req=0 throughout, clr_busy stays high for exactly DEPTH cycles.
- Simultaneous events:
  - VGA always beats clear.
  - Starved game beats VGA only in IDLE.
  - A read and a write to the same address in adjacent cycles return RAM ordering, i.e. the write is visible to the next-cycle read.

Decomposition:
- Package board_arb_pkg holds:
  - ADDR_W and DEPTH defaults,
  - state enum {ST_IDLE, ST_CLEAR},
  - owner enum {OWN_NONE, OWN_VGA, OWN_GL, OWN_CLR} used for the read-return pipeline tag.
- One sub-module: board_clear_seq (clr_ptr counter, busy flag, done detection), with an advance input from the arbiter.
- The read-return pipeline is a 2-stage owner tag shift register in the top level.

Test Plan:
- Reset: assert reset=0 mid-clear at clr_ptr=100 -> clr_busy=0, vga_bit=0, gl_rvalid=0 immediately; mem_we=0 while low.
- VGA read: RAM[5]=1, vga_req=1 with vga_addr=5 in cycle N -> vga_bit=1 in N+2, vga_miss=0, gl_gnt=0.
- Game read, idle VGA: RAM[7]=1, gl_req=1, gl_we=0, gl_addr=7 in N -> gl_gnt=1 in N, gl_rvalid=1 and gl_rdata=1 in N+2 only.
- Starvation: vga_req held 1, gl_req write addr 9 data 1 from cycle 0 -> gl_gnt first high in cycle 15; vga_miss=1 only in cycle 17; a later VGA read of addr 9 returns 1.
- Clear under load: all cells 1, clr_start pulse, vga_req toggling 1/0 every cycle -> clr_busy high 1024 cycles; gl_req during clear gets no gl_gnt; afterwards reads of 0, 255 and 511 return 0.
- Out of range: DEPTH=200, game write addr 300 -> gl_gnt=1, mem_we=0; a game read of addr 300 returns gl_rdata=0.
